keysw_input: RTL and testbench



---
 rtl/keysw_input_pkg.sv | 14 +
 rtl/keysw_debounce.sv | 63 ++++++
 rtl/keysw_input.sv | 113 +++++++++++
 tb/tb_keysw_input.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/keysw_input_pkg.sv
// Shared register map and address type for the keysw_input key/switch reader.
package keysw_input_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_STATE = 2'd0;
  localparam reg_addr_t REG_MASK  = 2'd1;
  localparam reg_addr_t REG_EDGE  = 2'd2;
  localparam reg_addr_t REG_RAW   = 2'd3;

endpackage

// File: rtl/keysw_debounce.sv
// One pin: 2-FF synchronizer, stability counter and press-rise pulse.
// With KEYSW_INPUT_RAW_READ_EN defined the synchronized undebounced level is exported.
module keysw_debounce
  import keysw_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic pressed,
  output logic stable,
  output logic rise_c
`ifdef KEYSW_INPUT_RAW_READ_EN
  ,
  output logic raw
`endif
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= pressed;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Any sample matching the accepted level restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign stable = stable_q;
  assign rise_c = stable_d & ~stable_q;

`ifdef KEYSW_INPUT_RAW_READ_EN
  assign raw = s2_q;
`endif

endmodule

// File: rtl/keysw_input.sv
// Debounced key/switch bank behind a 4-register bus slave with sticky press capture and maskable irq.
// Define KEYSW_INPUT_RAW_READ_EN to make address 3 return the synchronized, undebounced pins.
module keysw_input
  import keysw_input_pkg::*;
#(
  parameter int unsigned INPUTS          = 4,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        ctrl_address,
  input  logic              ctrl_read,
  output logic [31:0]       ctrl_readdata,
  input  logic              ctrl_write,
  input  logic [31:0]       ctrl_writedata,
  input  logic [INPUTS-1:0] key_in,
  output logic              irq
);

  localparam logic [INPUTS-1:0] POLARITY = {INPUTS{ACTIVE_LOW}};

  logic [INPUTS-1:0] pressed;
  logic [INPUTS-1:0] stable;
  logic [INPUTS-1:0] rise_c;
`ifdef KEYSW_INPUT_RAW_READ_EN
  logic [INPUTS-1:0] raw;
`endif

  assign pressed = key_in ^ POLARITY;

  for (genvar i = 0; i < INPUTS; i++) begin : g_pin
    keysw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .pressed(pressed[i]),
      .stable (stable[i]),
      .rise_c (rise_c[i])
`ifdef KEYSW_INPUT_RAW_READ_EN
      ,
      .raw    (raw[i])
`endif
    );
  end

  logic [INPUTS-1:0] mask_q;
  logic [INPUTS-1:0] mask_d;
  logic [INPUTS-1:0] edge_cap_q;
  logic [INPUTS-1:0] edge_cap_d;
  logic [DATA_W-1:0] readdata_q;
  logic [DATA_W-1:0] readdata_d;
  logic [DATA_W-1:0] rd_mux_c;
  logic              irq_q;
  logic              irq_d;
  logic [INPUTS-1:0] wdata_c;
  logic              unused_wdata;

  // Write data above the pin count has no destination.
  assign wdata_c      = ctrl_writedata[INPUTS-1:0];
  assign unused_wdata = ^(ctrl_writedata >> INPUTS);

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q     <= '0;
      edge_cap_q <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      edge_cap_q <= edge_cap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    rd_mux_c = '0;
    case (reg_addr_t'(ctrl_address))
      REG_STATE: rd_mux_c = DATA_W'(stable);
      REG_MASK:  rd_mux_c = DATA_W'(mask_q);
      REG_EDGE:  rd_mux_c = DATA_W'(edge_cap_q);
`ifdef KEYSW_INPUT_RAW_READ_EN
      REG_RAW:   rd_mux_c = DATA_W'(raw);
`endif
      default:   rd_mux_c = '0;
    endcase
  end

  // Reads see pre-write state; a new press beats a same-cycle clear.
  always_comb begin
    mask_d     = mask_q;
    edge_cap_d = edge_cap_q | rise_c;
    readdata_d = readdata_q;
    irq_d      = |(edge_cap_q & mask_q);
    if (ctrl_write) begin
      if (reg_addr_t'(ctrl_address) == REG_MASK) begin
        mask_d = wdata_c;
      end
      if (reg_addr_t'(ctrl_address) == REG_EDGE) begin
        edge_cap_d = (edge_cap_q & ~wdata_c) | rise_c;
      end
    end
    if (ctrl_read) begin
      readdata_d = rd_mux_c;
    end
  end

  assign ctrl_readdata = readdata_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_keysw_input.sv
// Scoreboard bench for keysw_input (INPUTS=4, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4).
module tb_keysw_input;
  import keysw_input_pkg::*;

`ifdef KEYSW_INPUT_RAW_READ_EN
  localparam logic [31:0] RAW_EXP = 32'h5;
`else
  localparam logic [31:0] RAW_EXP = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ctrl_address;
  logic        ctrl_read;
  logic [31:0] ctrl_readdata;
  logic        ctrl_write;
  logic [31:0] ctrl_writedata;
  logic [3:0]  key_in;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_exp_q[$];
  string       rd_tag_q[$];
  logic        irq_exp_q[$];
  string       irq_tag_q[$];
  logic        rd_v = 1'b0;

  keysw_input #(
    .INPUTS         (4),
    .ACTIVE_LOW     (1'b1),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ctrl_address  (ctrl_address),
    .ctrl_read     (ctrl_read),
    .ctrl_readdata (ctrl_readdata),
    .ctrl_write    (ctrl_write),
    .ctrl_writedata(ctrl_writedata),
    .key_in        (key_in),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  // Read data becomes valid one cycle after the strobe is sampled.
  always @(posedge clk) rd_v <= ctrl_read & ~reset;

  always @(negedge clk) begin
    if (rd_v) begin
      checks++;
      if (rd_exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read got %h required none", ctrl_readdata);
      end else begin
        logic [31:0] e;
        string       t;
        e = rd_exp_q.pop_front();
        t = rd_tag_q.pop_front();
        if (ctrl_readdata !== e) begin
          errors++;
          $display("FAIL %s readdata got %h required %h", t, ctrl_readdata, e);
        end
      end
    end
    if (irq_exp_q.size() != 0) begin
      logic  ei;
      string ti;
      ei = irq_exp_q.pop_front();
      ti = irq_tag_q.pop_front();
      checks++;
      if (irq !== ei) begin
        errors++;
        $display("FAIL %s irq got %b required %b", ti, irq, ei);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string t);
    ctrl_address = a;
    ctrl_read    = 1'b1;
    rd_exp_q.push_back(e);
    rd_tag_q.push_back(t);
    tick();
    ctrl_read = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    ctrl_address   = a;
    ctrl_writedata = d;
    ctrl_write     = 1'b1;
    tick();
    ctrl_write = 1'b0;
  endtask

  task automatic chk_irq(input logic e, input string t);
    irq_exp_q.push_back(e);
    irq_tag_q.push_back(t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ctrl_address = '0; ctrl_read = 1'b0; ctrl_write = 1'b0;
    ctrl_writedata = '0; key_in = 4'hF;
    repeat (3) tick();
    reset = 1'b0;

    rd(REG_STATE, 32'h0, "reset_state");
    rd(REG_MASK,  32'h0, "reset_mask");
    rd(REG_EDGE,  32'h0, "reset_edge");
    chk_irq(1'b0, "reset_irq");
    repeat (8) tick();
    rd(REG_EDGE, 32'h0, "no_edge_after_reset");

    // Press key 2: stable at edge 6, irq at edge 7.
    wr(REG_MASK, 32'h4);
    key_in[2] = 1'b0;
    repeat (4) tick();
    rd(REG_STATE, 32'h0, "press_state_early");
    chk_irq(1'b0, "press_irq_e5");
    tick();
    chk_irq(1'b0, "press_irq_e6");
    tick();
    chk_irq(1'b1, "press_irq_e7");
    rd(REG_STATE, 32'h4, "press_state");
    rd(REG_EDGE,  32'h4, "press_edge");

    // Bounce on key 0, then settle pressed.
    for (int i = 0; i < 10; i++) begin
      key_in[0] = ~key_in[0];
      tick();
      tick();
    end
    key_in[0] = 1'b0;
    repeat (3) tick();
    rd(REG_EDGE,  32'h4, "bounce_edge_early");
    rd(REG_STATE, 32'h4, "bounce_state_early");
    tick();
    rd(REG_STATE, 32'h5, "bounce_state");
    rd(REG_EDGE,  32'h5, "bounce_edge_once");

    wr(REG_EDGE, 32'h1);
    rd(REG_EDGE, 32'h4, "w1c_edge");
    chk_irq(1'b1, "w1c_irq");

    key_in[2] = 1'b1;
    repeat (8) tick();
    rd(REG_STATE, 32'h1, "release_state");
    rd(REG_EDGE,  32'h4, "release_edge_kept");

    wr(REG_EDGE, 32'h4);
    chk_irq(1'b1, "clear_irq_lag");
    tick();
    chk_irq(1'b0, "clear_irq");

    // Clear lands on the same edge as the new press of key 2.
    key_in[2] = 1'b0;
    repeat (5) tick();
    wr(REG_EDGE, 32'h4);
    rd(REG_EDGE, 32'h4, "set_wins_edge");
    chk_irq(1'b1, "set_wins_irq");

    wr(REG_MASK, 32'h0);
    key_in = 4'hF;
    repeat (8) tick();
    key_in = 4'h0;
    repeat (8) tick();
    chk_irq(1'b0, "mask0_irq");
    rd(REG_EDGE,  32'hF, "all_edges");
    rd(REG_STATE, 32'hF, "all_pressed");
    wr(REG_MASK, 32'h8);
    chk_irq(1'b0, "mask_irq_lag");
    tick();
    chk_irq(1'b1, "mask_irq");

    key_in = 4'b1010;
    tick();
    tick();
    rd(REG_RAW, RAW_EXP, "raw_read");

    ctrl_address   = REG_MASK;
    ctrl_writedata = 32'h3;
    ctrl_read      = 1'b1;
    ctrl_write     = 1'b1;
    rd_exp_q.push_back(32'h8);
    rd_tag_q.push_back("rw_old_mask");
    tick();
    ctrl_read  = 1'b0;
    ctrl_write = 1'b0;
    rd(REG_MASK, 32'h3, "rw_new_mask");

    wr(REG_STATE, 32'hF);
    wr(REG_RAW, 32'hF);
    wr(REG_MASK, 32'hFFFF_FFF2);
    rd(REG_MASK,  32'h2, "mask_upper_ignored");
    rd(REG_STATE, 32'h5, "state_write_ignored");

    // Reset mid-debounce discards progress and captured edges.
    key_in = 4'h0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd(REG_STATE, 32'h0, "reset2_state");
    rd(REG_EDGE,  32'h0, "reset2_edge");
    chk_irq(1'b0, "reset2_irq");

    repeat (3) tick();
    checks++;
    if (rd_exp_q.size() != 0 || irq_exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d reads %0d irqs required 0", rd_exp_q.size(), irq_exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
